// File: rtl/traffic_pkg.sv
// Shared encodings for the two-approach intersection controller:
// phase codes and lamp-vector bit positions.
package traffic_pkg;

    typedef enum logic [3:0] {
        AR_A  = 4'd0,
        A_RY  = 4'd1,
        A_G   = 4'd2,
        A_Y   = 4'd3,
        PED   = 4'd4,
        AR_B  = 4'd5,
        B_RY  = 4'd6,
        B_G   = 4'd7,
        B_Y   = 4'd8,
        FLASH = 4'd9
    } phase_e;

    localparam int LAMP_W  = 7;
    localparam int L_A_RED = 6;
    localparam int L_A_YEL = 5;
    localparam int L_A_GRN = 4;
    localparam int L_B_RED = 3;
    localparam int L_B_YEL = 2;
    localparam int L_B_GRN = 1;
    localparam int L_WALK  = 0;

endpackage

// File: rtl/tl_phase_timer.sv
// Phase dwell counter: synchronous clear, saturating increment.
module tl_phase_timer #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr_i,
    output logic [CNT_W-1:0] cnt_o
);

    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (cnt_q != '1) begin
            cnt_d = cnt_q + ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/traffic_intersection_ctrl.sv
// Main/side road intersection controller with demand-driven main green,
// latched pedestrian phase and night flashing-yellow mode.
module traffic_intersection_ctrl
    import traffic_pkg::*;
#(
    parameter int CNT_W        = 16,
    parameter int ALL_RED_T    = 2,
    parameter int RY_T         = 2,
    parameter int GREEN_MIN_T  = 4,
    parameter int GREEN_MAX_T  = 10,
    parameter int SIDE_GREEN_T = 5,
    parameter int YELLOW_T     = 3,
    parameter int PED_T        = 6,
    parameter int FLASH_HALF_T = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       side_req,
    input  logic       ped_btn,
    input  logic       night,
    output logic       a_red,
    output logic       a_yellow,
    output logic       a_green,
    output logic       b_red,
    output logic       b_yellow,
    output logic       b_green,
    output logic       walk,
    output logic [3:0] phase
);

    localparam logic [CNT_W-1:0] ALL_RED_L = CNT_W'(ALL_RED_T - 1);
    localparam logic [CNT_W-1:0] RY_L      = CNT_W'(RY_T - 1);
    localparam logic [CNT_W-1:0] GMIN_L    = CNT_W'(GREEN_MIN_T - 1);
    localparam logic [CNT_W-1:0] GMAX_L    = CNT_W'(GREEN_MAX_T - 1);
    localparam logic [CNT_W-1:0] SIDE_L    = CNT_W'(SIDE_GREEN_T - 1);
    localparam logic [CNT_W-1:0] YEL_L     = CNT_W'(YELLOW_T - 1);
    localparam logic [CNT_W-1:0] PED_L     = CNT_W'(PED_T - 1);
    localparam logic [CNT_W-1:0] FLASH_L   = CNT_W'(FLASH_HALF_T - 1);

    phase_e             state_q, state_d;
    logic               ped_q, ped_d;
    logic               flash_q, flash_d;
    logic [CNT_W-1:0]   cnt;
    logic               cnt_clr;
    logic               flash_tick;
    logic [LAMP_W-1:0]  lamps;

    tl_phase_timer #(
        .CNT_W (CNT_W)
    ) u_timer (
        .clk   (clk),
        .rst   (rst),
        .clr_i (cnt_clr),
        .cnt_o (cnt)
    );

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            AR_A:  if (cnt == ALL_RED_L) state_d = night ? FLASH : A_RY;
            A_RY:  if (cnt == RY_L) state_d = A_G;
            A_G:   if ((cnt >= GMIN_L && (side_req || ped_q)) ||
                       cnt == GMAX_L) state_d = A_Y;
            A_Y:   if (cnt == YEL_L) state_d = ped_q ? PED : AR_B;
            PED:   if (cnt == PED_L) state_d = AR_B;
            AR_B:  if (cnt == ALL_RED_L) state_d = night ? FLASH : B_RY;
            B_RY:  if (cnt == RY_L) state_d = B_G;
            B_G:   if (cnt == SIDE_L) state_d = B_Y;
            B_Y:   if (cnt == YEL_L) state_d = AR_A;
            FLASH: if (!night) state_d = AR_A;
            default: state_d = AR_A;
        endcase
    end

    // In FLASH the timer doubles as the half-period divider.
    assign flash_tick = (state_q == FLASH) && (cnt == FLASH_L);
    assign cnt_clr    = (state_d != state_q) || flash_tick;

    always_comb begin
        flash_d = 1'b0;
        if (state_d == FLASH) begin
            if (state_q != FLASH) begin
                flash_d = 1'b1;
            end else begin
                flash_d = flash_tick ? ~flash_q : flash_q;
            end
        end
    end

    always_comb begin
        ped_d = (ped_q && !(state_d == PED && state_q != PED)) || ped_btn;
        if (state_q == FLASH || state_d == FLASH) begin
            ped_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= AR_A;
            ped_q   <= 1'b0;
            flash_q <= 1'b0;
        end else begin
            state_q <= state_d;
            ped_q   <= ped_d;
            flash_q <= flash_d;
        end
    end

    always_comb begin
        lamps = '0;
        unique case (state_q)
            AR_A, AR_B: begin
                lamps[L_A_RED] = 1'b1;
                lamps[L_B_RED] = 1'b1;
            end
            A_RY: begin
                lamps[L_A_RED] = 1'b1;
                lamps[L_A_YEL] = 1'b1;
                lamps[L_B_RED] = 1'b1;
            end
            A_G: begin
                lamps[L_A_GRN] = 1'b1;
                lamps[L_B_RED] = 1'b1;
            end
            A_Y: begin
                lamps[L_A_YEL] = 1'b1;
                lamps[L_B_RED] = 1'b1;
            end
            PED: begin
                lamps[L_A_RED] = 1'b1;
                lamps[L_B_RED] = 1'b1;
                lamps[L_WALK]  = 1'b1;
            end
            B_RY: begin
                lamps[L_A_RED] = 1'b1;
                lamps[L_B_RED] = 1'b1;
                lamps[L_B_YEL] = 1'b1;
            end
            B_G: begin
                lamps[L_A_RED] = 1'b1;
                lamps[L_B_GRN] = 1'b1;
            end
            B_Y: begin
                lamps[L_A_RED] = 1'b1;
                lamps[L_B_YEL] = 1'b1;
            end
            FLASH: begin
                lamps[L_A_YEL] = flash_q;
                lamps[L_B_YEL] = flash_q;
            end
            default: lamps = '0;
        endcase
    end

    assign a_red    = lamps[L_A_RED];
    assign a_yellow = lamps[L_A_YEL];
    assign a_green  = lamps[L_A_GRN];
    assign b_red    = lamps[L_B_RED];
    assign b_yellow = lamps[L_B_YEL];
    assign b_green  = lamps[L_B_GRN];
    assign walk     = lamps[L_WALK];
    assign phase    = state_q;

endmodule

// File: tb/tb_traffic_intersection_ctrl.sv
// Self-checking bench for traffic_intersection_ctrl: fixed vector table,
// directed corner sequences and random stimulus against a timing model.
module tb_traffic_intersection_ctrl;

    localparam int ALL_RED = 2;
    localparam int RY      = 2;
    localparam int GMIN    = 4;
    localparam int GMAX    = 10;
    localparam int SIDE    = 5;
    localparam int YEL     = 3;
    localparam int PEDT    = 6;
    localparam int HALF    = 2;

    // {a_r, a_y, a_g, b_r, b_y, b_g, walk} per phase; FLASH filled at runtime
    localparam logic [6:0] PAT [10] = '{
        7'b100_100_0, 7'b110_100_0, 7'b001_100_0, 7'b010_100_0,
        7'b100_100_1, 7'b100_100_0, 7'b100_110_0, 7'b100_001_0,
        7'b100_010_0, 7'b000_000_0
    };

    localparam int DUR [10] = '{
        ALL_RED, RY, 0, YEL, PEDT, ALL_RED, RY, SIDE, YEL, 0
    };

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       side_req = 1'b0;
    logic       ped_btn = 1'b0;
    logic       night = 1'b0;
    logic       a_red, a_yellow, a_green;
    logic       b_red, b_yellow, b_green;
    logic       walk;
    logic [3:0] phase;
    logic [6:0] dut_l;

    int vecs = 0;
    int errs = 0;

    int m_ph = 0;
    int m_t  = 0;
    bit m_ped = 1'b0;

    always #5 clk = ~clk;

    traffic_intersection_ctrl #(
        .CNT_W        (16),
        .ALL_RED_T    (ALL_RED),
        .RY_T         (RY),
        .GREEN_MIN_T  (GMIN),
        .GREEN_MAX_T  (GMAX),
        .SIDE_GREEN_T (SIDE),
        .YELLOW_T     (YEL),
        .PED_T        (PEDT),
        .FLASH_HALF_T (HALF)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .side_req (side_req),
        .ped_btn  (ped_btn),
        .night    (night),
        .a_red    (a_red),
        .a_yellow (a_yellow),
        .a_green  (a_green),
        .b_red    (b_red),
        .b_yellow (b_yellow),
        .b_green  (b_green),
        .walk     (walk),
        .phase    (phase)
    );

    assign dut_l = {a_red, a_yellow, a_green, b_red, b_yellow, b_green, walk};

    function automatic logic [6:0] exp_lamps(input int ph, input int t);
        logic [6:0] v;
        bit f;
        v = PAT[ph];
        if (ph == 9) begin
            f = ((t / HALF) % 2) == 0;
            v = {1'b0, f, 1'b0, 1'b0, f, 1'b0, 1'b0};
        end
        return v;
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        vecs++;
        if (act != exp) begin
            errs++;
            $display("FAIL %s: got %0d expected %0d at t=%0t",
                     nm, act, exp, $time);
        end
    endtask

    // Timing model: each phase is a duration, A_G is demand-limited,
    // FLASH lasts while night is held.
    task automatic model_step(input bit s, input bit p, input bit n,
                              input bit r);
        int  nxt;
        bit  last;
        if (r) begin
            m_ph  = 0;
            m_t   = 0;
            m_ped = 1'b0;
            return;
        end
        nxt  = m_ph;
        last = (m_t == DUR[m_ph] - 1);
        case (m_ph)
            0: if (last) nxt = n ? 9 : 1;
            5: if (last) nxt = n ? 9 : 6;
            2: if ((m_t + 1 >= GMIN && (s || m_ped)) || m_t + 1 == GMAX)
                   nxt = 3;
            3: if (last) nxt = m_ped ? 4 : 5;
            8: if (last) nxt = 0;
            9: if (!n) nxt = 0;
            default: if (last) nxt = m_ph + 1;
        endcase
        if (nxt == 9 || m_ph == 9) m_ped = 1'b0;
        else if (nxt == 4 && m_ph != 4) m_ped = p;
        else m_ped = m_ped | p;
        m_t  = (nxt != m_ph) ? 0 : m_t + 1;
        m_ph = nxt;
    endtask

    task automatic tick(input bit s, input bit p, input bit n, input bit r);
        bit unsafe;
        side_req = s;
        ped_btn  = p;
        night    = n;
        rst      = r;
        @(posedge clk);
        model_step(s, p, n, r);
        #1;
        chk("phase", int'(phase), m_ph);
        chk("lamps", int'(dut_l), int'(exp_lamps(m_ph, m_t)));
        unsafe = ((a_green | a_yellow) && (b_green | b_yellow) && phase != 4'd9)
               || (walk && phase != 4'd4);
        chk("safety", int'(unsafe), 0);
    endtask

    task automatic wait_ph(input int ph, input bit s, input bit p, input bit n);
        int g = 0;
        while (int'(phase) != ph && g < 200) begin
            tick(s, p, n, 1'b0);
            g++;
        end
        chk("reach_phase", int'(phase), ph);
    endtask

    task automatic measure(input int ph, input bit s, input bit p,
                           input bit n, output int len);
        int g = 0;
        len = 0;
        while (int'(phase) != ph && g < 200) begin
            tick(s, p, n, 1'b0);
            g++;
        end
        while (int'(phase) == ph && g < 400) begin
            len++;
            tick(s, p, n, 1'b0);
            g++;
        end
    endtask

    typedef struct {
        bit         s, p, n, r;
        int         ph;
        logic [6:0] l;
    } vec_t;

    initial begin
        vec_t tbl[$];
        vec_t v;
        int   rph[9] = '{0, 1, 2, 3, 5, 6, 7, 8, 0};
        int   rln[9] = '{1, 2, 10, 3, 2, 2, 5, 3, 2};
        int   len;
        int   prev;
        bit   n;

        // Idle cycle with no demand: reset record, then full round
        v = '{s: 1'b0, p: 1'b0, n: 1'b0, r: 1'b1, ph: 0, l: PAT[0]};
        tbl.push_back(v);
        for (int i = 0; i < 9; i++) begin
            for (int k = 0; k < rln[i]; k++) begin
                v = '{s: 1'b0, p: 1'b0, n: 1'b0, r: 1'b0,
                      ph: rph[i], l: PAT[rph[i]]};
                tbl.push_back(v);
            end
        end
        for (int i = 0; i < tbl.size(); i++) begin
            tick(tbl[i].s, tbl[i].p, tbl[i].n, tbl[i].r);
            chk("tbl_phase", int'(phase), tbl[i].ph);
            chk("tbl_lamps", int'(dut_l), int'(tbl[i].l));
        end

        // Side demand from reset: minimum green
        tick(1'b0, 1'b0, 1'b0, 1'b1);
        measure(2, 1'b1, 1'b0, 1'b0, len);
        chk("side_min_green", len, GMIN);

        // Side demand arriving late in green
        tick(1'b0, 1'b0, 1'b0, 1'b1);
        wait_ph(2, 1'b0, 1'b0, 1'b0);
        repeat (6) tick(1'b0, 1'b0, 1'b0, 1'b0);
        chk("late_still_green", int'(phase), 2);
        tick(1'b1, 1'b0, 1'b0, 1'b0);
        chk("late_exit", int'(phase), 3);

        // Pedestrian pulse during A_RY, second pulse on PED entry
        tick(1'b0, 1'b0, 1'b0, 1'b1);
        wait_ph(1, 1'b0, 1'b0, 1'b0);
        tick(1'b0, 1'b1, 1'b0, 1'b0);
        measure(2, 1'b0, 1'b0, 1'b0, len);
        chk("ped_green_len", len, GMIN);
        measure(3, 1'b0, 1'b0, 1'b0, len);
        chk("ped_yellow_len", len, YEL);
        chk("ped_entered", int'(phase), 4);
        chk("ped_walk", int'(walk), 1);
        tick(1'b0, 1'b1, 1'b0, 1'b0);
        measure(4, 1'b0, 1'b0, 1'b0, len);
        chk("ped_len", len + 1, PEDT);
        chk("ped_then_arb", int'(phase), 5);
        measure(2, 1'b0, 1'b0, 1'b0, len);
        chk("ped2_green_len", len, GMIN);
        measure(4, 1'b0, 1'b0, 1'b0, len);
        chk("ped2_len", len, PEDT);

        // Night raised mid-green takes effect only at AR_B end
        tick(1'b0, 1'b0, 1'b0, 1'b1);
        wait_ph(2, 1'b0, 1'b0, 1'b0);
        prev = 2;
        for (int g = 0; g < 100 && int'(phase) != 9; g++) begin
            prev = int'(phase);
            tick(1'b0, 1'b0, 1'b1, 1'b0);
        end
        chk("flash_reached", int'(phase), 9);
        chk("flash_from_arb", prev, 5);
        for (int k = 0; k < 8; k++) begin
            chk("flash_yel", int'(a_yellow & b_yellow), ((k / 2) % 2 == 0) ? 1 : 0);
            chk("flash_reds", int'(a_red | b_red), 0);
            tick(1'b0, 1'b1, 1'b1, 1'b0);
        end
        tick(1'b0, 1'b0, 1'b0, 1'b0);
        chk("flash_exit", int'(phase), 0);
        chk("flash_exit_reds", int'(a_red & b_red), 1);
        measure(2, 1'b0, 1'b0, 1'b0, len);
        chk("flash_ped_ignored", len, GMAX);

        // Reset mid side-green clears pending pedestrian request
        wait_ph(7, 1'b0, 1'b0, 1'b0);
        tick(1'b0, 1'b1, 1'b0, 1'b0);
        tick(1'b0, 1'b0, 1'b0, 1'b1);
        chk("rst_phase", int'(phase), 0);
        chk("rst_lamps", int'(dut_l), int'(PAT[0]));
        measure(0, 1'b0, 1'b0, 1'b0, len);
        chk("rst_allred_len", len, ALL_RED);
        measure(2, 1'b0, 1'b0, 1'b0, len);
        chk("rst_ped_cleared", len, GMAX);

        // Random traffic
        tick(1'b0, 1'b0, 1'b0, 1'b1);
        n = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(29, 0) == 0) n = ~n;
            tick(1'($urandom_range(1, 0)),
                 ($urandom_range(7, 0) == 0),
                 n,
                 ($urandom_range(299, 0) == 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
